cmd_sched: RTL and testbench

- Command scheduler between UART_wrapper (host command source) and cmd_proc (Knight move/calibrate executor).
- Buffers host commands in a small FIFO so the host can queue several moves back-to-back.
- Issues queued commands to cmd_proc one at a time and waits for each to complete before issuing the next.
- Generates the host response: 0x5A after intermediate completions, 0xA5 when the queue has drained.

---
 rtl/cmd_sched.sv | 144 ++++++++++++++
 tb/tb_cmd_sched.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_sched.sv
// Command scheduler: queues host commands in a small FIFO and feeds them to cmd_proc
// one at a time. After each completion it returns 0x5A, or 0xA5 once the queue is empty.
module cmd_sched #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [15:0]              host_cmd,
  input  logic                     host_cmd_rdy,
  output logic                     clr_host_rdy,
  output logic [15:0]              cmd,
  output logic                     cmd_rdy,
  input  logic                     clr_cmd_rdy,
  input  logic                     done,
  output logic [7:0]               resp,
  output logic                     send_resp,
  output logic [$clog2(DEPTH):0]   q_cnt,
  output logic                     ovfl
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [7:0] RESP_MORE  = 8'h5A;
  localparam logic [7:0] RESP_DRAIN = 8'hA5;

  logic [15:0]   mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    state_q, state_d;
  logic          clr_host_q, clr_host_d;
  logic          ovfl_q, ovfl_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          cmd_rdy_q, cmd_rdy_d;
  logic [7:0]    resp_q, resp_d;
  logic          send_resp_q, send_resp_d;
  logic          head_valid_q, head_valid_d;

  logic take, is_flush, push_req, pop, full, push;

  // A host word is taken only when we did not acknowledge it the cycle before.
  assign take     = host_cmd_rdy & ~clr_host_q;
  assign is_flush = take & (host_cmd[15:12] == 4'hF);
  assign push_req = take & ~is_flush;
  // head_valid guards the pop so a flushed head never removes a newer entry.
  assign pop      = (state_q == ISSUE) & clr_cmd_rdy & head_valid_q;
  assign full     = (cnt_q == CW'(DEPTH));
  assign push     = push_req & (~full | pop);

  always_comb begin
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    clr_host_d = take;
    ovfl_d     = ovfl_q | (push_req & ~push);
    if (is_flush) begin
      wr_ptr_d = rd_ptr_d;
      cnt_d    = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      cnt_d    = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    cmd_rdy_d    = cmd_rdy_q;
    resp_d       = resp_q;
    send_resp_d  = 1'b0;
    head_valid_d = head_valid_q;
    case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          cmd_d        = mem_q[rd_ptr_q];
          cmd_rdy_d    = 1'b1;
          head_valid_d = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (clr_cmd_rdy) begin
          cmd_rdy_d    = 1'b0;
          head_valid_d = 1'b0;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (done) begin
          resp_d      = (cnt_q == '0) ? RESP_DRAIN : RESP_MORE;
          send_resp_d = 1'b1;
          state_d     = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
    if (is_flush) head_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= host_cmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      state_q      <= IDLE;
      clr_host_q   <= 1'b0;
      ovfl_q       <= 1'b0;
      cmd_q        <= '0;
      cmd_rdy_q    <= 1'b0;
      resp_q       <= '0;
      send_resp_q  <= 1'b0;
      head_valid_q <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      clr_host_q   <= clr_host_d;
      ovfl_q       <= ovfl_d;
      cmd_q        <= cmd_d;
      cmd_rdy_q    <= cmd_rdy_d;
      resp_q       <= resp_d;
      send_resp_q  <= send_resp_d;
      head_valid_q <= head_valid_d;
    end
  end

  assign clr_host_rdy = clr_host_q;
  assign cmd          = cmd_q;
  assign cmd_rdy      = cmd_rdy_q;
  assign resp         = resp_q;
  assign send_resp    = send_resp_q;
  assign q_cnt        = cnt_q;
  assign ovfl         = ovfl_q;

endmodule

// File: tb/tb_cmd_sched.sv
// Bench for cmd_sched: directed scenarios, then random host/cmd_proc traffic
// checked against a queue-based reference model.
module tb_cmd_sched;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] host_cmd;
  logic        host_cmd_rdy;
  logic        clr_host_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        done;
  logic [7:0]  resp;
  logic        send_resp;
  logic [2:0]  q_cnt;
  logic        ovfl;

  int tests = 0;
  int fails = 0;

  cmd_sched #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .host_cmd(host_cmd), .host_cmd_rdy(host_cmd_rdy),
    .clr_host_rdy(clr_host_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .done(done), .resp(resp), .send_resp(send_resp), .q_cnt(q_cnt), .ovfl(ovfl)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push_word(input logic [15:0] w);
    host_cmd     = w;
    host_cmd_rdy = 1'b1;
    tick();
    host_cmd_rdy = 1'b0;
    tick();
  endtask

  // Acts as cmd_proc for one command: take it, then complete it after one WAIT cycle.
  task automatic run_cmd(input logic [15:0] exp_cmd, input logic [7:0] exp_resp);
    for (int i = 0; i < 20 && !cmd_rdy; i++) tick();
    chk("issue_wait", cmd_rdy, 1);
    chk("issue_cmd", cmd, exp_cmd);
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    chk("rdy_drop", cmd_rdy, 0);
    tick();
    chk("rdy_low_wait", cmd_rdy, 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("send_resp", send_resp, 1);
    chk("resp", resp, exp_resp);
    tick();
    chk("send_one_cycle", send_resp, 0);
  endtask

  // reference model state for the random phase
  logic [15:0] mq[$];
  bit          m_head_in;
  bit          m_ovfl;
  bit          m_clr;
  bit          exp_send;
  logic [7:0]  exp_resp_v;
  int          pph;
  int          dly;
  int          stall;
  int          pre_size;
  logic [15:0] pre_front;
  logic [15:0] held_cmd;
  bit          take;
  bit          flush;
  logic [3:0]  op;

  initial begin
    rst_n = 1'b0; host_cmd = '0; host_cmd_rdy = 1'b0; clr_cmd_rdy = 1'b0; done = 1'b0;
    tick();
    chk("rst_cmd", cmd, 0);
    chk("rst_cmd_rdy", cmd_rdy, 0);
    chk("rst_resp", resp, 0);
    chk("rst_send", send_resp, 0);
    chk("rst_clr_host", clr_host_rdy, 0);
    chk("rst_ovfl", ovfl, 0);
    chk("rst_qcnt", q_cnt, 0);
    rst_n = 1'b1;
    tick();

    // spurious done / clr_cmd_rdy in IDLE are ignored
    done = 1'b1; clr_cmd_rdy = 1'b1;
    tick();
    done = 1'b0; clr_cmd_rdy = 1'b0;
    chk("spur_done", send_resp, 0);
    chk("spur_clr_rdy", cmd_rdy, 0);

    // single cal command; host_cmd_rdy held two cycles must capture once
    host_cmd = 16'h2000; host_cmd_rdy = 1'b1;
    tick();
    chk("t1_clr_host", clr_host_rdy, 1);
    chk("t1_qcnt", q_cnt, 1);
    chk("t1_no_rdy_yet", cmd_rdy, 0);
    tick();
    host_cmd_rdy = 1'b0;
    chk("t1_clr_host_pulse", clr_host_rdy, 0);
    chk("t1_single_capture", q_cnt, 1);
    chk("t1_latency", cmd_rdy, 1);
    run_cmd(16'h2000, 8'hA5);
    chk("t1_qcnt_end", q_cnt, 0);
    tick();
    chk("t1_resp_hold", resp, 8'hA5);

    // three queued moves in order with 2-cycle gap
    push_word(16'h4001);
    push_word(16'h4002);
    push_word(16'h4003);
    chk("t2_qcnt", q_cnt, 3);
    run_cmd(16'h4001, 8'h5A);
    tick();
    chk("t2_gap1", cmd_rdy, 1);
    run_cmd(16'h4002, 8'h5A);
    tick();
    chk("t2_gap2", cmd_rdy, 1);
    run_cmd(16'h4003, 8'hA5);
    repeat (4) tick();
    chk("t2_idle", cmd_rdy, 0);

    // overflow: cmd_proc held, six pushes
    for (int k = 1; k <= 6; k++) push_word(16'h1000 + 16'(k));
    chk("t3_qcnt_full", q_cnt, 4);
    chk("t3_ovfl", ovfl, 1);
    chk("t3_present", cmd, 16'h1001);
    run_cmd(16'h1001, 8'h5A);
    run_cmd(16'h1002, 8'h5A);
    run_cmd(16'h1003, 8'h5A);
    run_cmd(16'h1004, 8'hA5);
    repeat (6) tick();
    chk("t3_no_extra", cmd_rdy, 0);
    chk("t3_ovfl_sticky", ovfl, 1);

    // flush while first command is in WAIT
    do_reset();
    push_word(16'h4001);
    push_word(16'h4002);
    push_word(16'h4003);
    for (int i = 0; i < 20 && !cmd_rdy; i++) tick();
    chk("t4_cmd", cmd, 16'h4001);
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    host_cmd = 16'hF000; host_cmd_rdy = 1'b1;
    tick();
    host_cmd_rdy = 1'b0;
    chk("t4_flush_qcnt", q_cnt, 0);
    chk("t4_flush_noresp", send_resp, 0);
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("t4_send", send_resp, 1);
    chk("t4_resp", resp, 8'hA5);
    repeat (6) tick();
    chk("t4_no_more", cmd_rdy, 0);

    // full FIFO: pop and push on the same edge
    do_reset();
    for (int k = 1; k <= 4; k++) push_word(16'h3000 + 16'(k));
    chk("t5_full", q_cnt, 4);
    host_cmd = 16'h3005; host_cmd_rdy = 1'b1; clr_cmd_rdy = 1'b1;
    tick();
    host_cmd_rdy = 1'b0; clr_cmd_rdy = 1'b0;
    chk("t5_qcnt", q_cnt, 4);
    chk("t5_ovfl", ovfl, 0);
    chk("t5_taken", clr_host_rdy, 1);
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("t5_resp", resp, 8'h5A);
    tick();
    run_cmd(16'h3002, 8'h5A);
    run_cmd(16'h3003, 8'h5A);
    run_cmd(16'h3004, 8'h5A);
    run_cmd(16'h3005, 8'hA5);

    // asynchronous reset during WAIT
    for (int k = 1; k <= 6; k++) push_word(16'h5000 + 16'(k));
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    tick();
    chk("t6_pre_ovfl", ovfl, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_cmd_rdy", cmd_rdy, 0);
    chk("t6_send", send_resp, 0);
    chk("t6_qcnt", q_cnt, 0);
    chk("t6_ovfl", ovfl, 0);
    tick();
    rst_n = 1'b1;
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("t6_no_resp", send_resp, 0);
    tick();
    chk("t6_no_resp2", send_resp, 0);
    chk("t6_idle", cmd_rdy, 0);

    // random traffic against the queue model
    do_reset();
    mq.delete();
    m_head_in = 0; m_ovfl = 0; m_clr = 0; pph = 0; dly = 0; stall = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (host_cmd_rdy && m_clr) begin
        host_cmd_rdy = 1'b0;
      end else if (!host_cmd_rdy && $urandom_range(0, 99) < 40) begin
        op = ($urandom_range(0, 99) < 4) ? 4'hF : 4'($urandom_range(0, 14));
        host_cmd = {op, 12'($urandom)};
        host_cmd_rdy = 1'b1;
      end
      clr_cmd_rdy = 1'b0;
      done = 1'b0;
      case (pph)
        0: done = ($urandom_range(0, 19) == 0);
        1: if (dly == 0) clr_cmd_rdy = 1'b1; else dly--;
        default: begin
          clr_cmd_rdy = ($urandom_range(0, 19) == 0);
          if (dly == 0) done = 1'b1; else dly--;
        end
      endcase

      pre_size  = mq.size();
      pre_front = (pre_size > 0) ? mq[0] : 16'h0;
      take      = host_cmd_rdy && !m_clr;
      flush     = take && (host_cmd[15:12] == 4'hF);
      exp_send  = done && (pph == 2);
      if (exp_send) exp_resp_v = (mq.size() == 0) ? 8'hA5 : 8'h5A;
      if (pph == 1 && clr_cmd_rdy) begin
        if (m_head_in) void'(mq.pop_front());
        m_head_in = 0;
      end
      if (take) begin
        if (flush) begin
          mq.delete();
          m_head_in = 0;
        end else if (mq.size() < DEPTH) begin
          mq.push_back(host_cmd);
        end else begin
          m_ovfl = 1;
        end
      end
      m_clr = take;

      tick();

      chk("r_clr_host", clr_host_rdy, m_clr);
      chk("r_qcnt", q_cnt, 32'(mq.size()));
      chk("r_ovfl", ovfl, m_ovfl);
      chk("r_send", send_resp, exp_send);
      if (exp_send) chk("r_resp", resp, exp_resp_v);
      case (pph)
        0: begin
          if (cmd_rdy) begin
            chk("r_issue_nonempty", (pre_size > 0), 1);
            chk("r_issue_cmd", cmd, pre_front);
            held_cmd  = cmd;
            m_head_in = !flush;
            pph   = 1;
            dly   = $urandom_range(0, 3);
            stall = 0;
          end else if (pre_size > 0) begin
            stall++;
            chk("r_issue_latency", (stall <= 2), 1);
          end
        end
        1: begin
          if (clr_cmd_rdy) begin
            chk("r_rdy_drop", cmd_rdy, 0);
            pph = 2;
            dly = $urandom_range(0, 4);
          end else begin
            chk("r_rdy_hold", cmd_rdy, 1);
            chk("r_cmd_hold", cmd, held_cmd);
          end
        end
        default: begin
          if (done) pph = 0;
          else chk("r_rdy_low_wait", cmd_rdy, 0);
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
